qp_mem_arbiter: RTL and testbench

//  Shares the single-port query-patch SRAM between two requesters: the kNN search engine
//  (port E) and the Wishbone debug controller (port W). Grants at most one access per cycle,

---
 rtl/qp_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_qp_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qp_mem_arbiter.sv
// Query-patch SRAM arbiter between the kNN engine (E) and the Wishbone debug port (W).
// Define QP_ARB_RR_EN for round-robin; default is fixed priority E>W with W anti-starvation.
module qp_mem_arbiter #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_ni,
  input  logic                             wbs_mode,
  input  logic                             eng_req,
  input  logic                             eng_we,
  input  logic [ADDR_W-1:0]                eng_addr,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] eng_wpatch,
  output logic                             eng_gnt,
  output logic                             eng_rvalid,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] eng_rpatch,
  input  logic                             wbs_req,
  input  logic                             wbs_we,
  input  logic [ADDR_W-1:0]                wbs_addr,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_wpatch,
  output logic                             wbs_gnt,
  output logic                             wbs_rvalid,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_rpatch,
  output logic                             mem_csb0,
  output logic                             mem_web0,
  output logic [ADDR_W-1:0]                mem_addr0,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_wpatch0,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0] mem_rpatch0,
  output logic [15:0]                      conflict_cnt
);

  localparam int PW = PATCH_SIZE * DATA_WIDTH;

  typedef enum logic {
    PORT_E = 1'b0,
    PORT_W = 1'b1
  } port_t;

  logic          wbsr;
  logic          gnt_e;
  logic          gnt_w;
  logic          e_rd_q;
  logic          w_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PW-1:0] wpatch_q;
  logic [15:0]   conflict_q;

`ifdef QP_ARB_RR_EN
  port_t last_q;
`else
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;
`endif

  // Grants are suppressed while reset is held so nothing reaches the SRAM.
  always_comb begin
    wbsr  = wbs_req & wbs_mode;
    gnt_e = 1'b0;
    gnt_w = 1'b0;
    if (wb_rst_ni) begin
`ifdef QP_ARB_RR_EN
      if (eng_req && wbsr) begin
        if (last_q == PORT_E) gnt_w = 1'b1;
        else                  gnt_e = 1'b1;
      end else begin
        gnt_e = eng_req;
        gnt_w = wbsr;
      end
`else
      if (wbsr && (!eng_req || starve_q == SW'(STARVE_MAX))) gnt_w = 1'b1;
      else                                                    gnt_e = eng_req;
`endif
    end
  end

  always_comb begin
    mem_csb0    = 1'b1;
    mem_web0    = 1'b1;
    mem_addr0   = addr_q;
    mem_wpatch0 = wpatch_q;
    if (gnt_e) begin
      mem_csb0    = 1'b0;
      mem_web0    = ~eng_we;
      mem_addr0   = eng_addr;
      mem_wpatch0 = eng_wpatch;
    end else if (gnt_w) begin
      mem_csb0    = 1'b0;
      mem_web0    = ~wbs_we;
      mem_addr0   = wbs_addr;
      mem_wpatch0 = wbs_wpatch;
    end
  end

  assign eng_gnt      = gnt_e;
  assign wbs_gnt      = gnt_w;
  // Read data returned during a reset cycle is discarded.
  assign eng_rvalid   = e_rd_q & wb_rst_ni;
  assign wbs_rvalid   = w_rd_q & wb_rst_ni;
  assign eng_rpatch   = mem_rpatch0;
  assign wbs_rpatch   = mem_rpatch0;
  assign conflict_cnt = conflict_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      e_rd_q     <= 1'b0;
      w_rd_q     <= 1'b0;
      addr_q     <= '0;
      wpatch_q   <= '0;
      conflict_q <= '0;
    end else begin
      e_rd_q <= gnt_e & ~eng_we;
      w_rd_q <= gnt_w & ~wbs_we;
      if (!mem_csb0) begin
        addr_q   <= mem_addr0;
        wpatch_q <= mem_wpatch0;
      end
      if (eng_req && wbsr && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
    end
  end

`ifdef QP_ARB_RR_EN
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni)  last_q <= PORT_E;
    else if (gnt_w)  last_q <= PORT_W;
    else if (gnt_e)  last_q <= PORT_E;
  end
`else
  // Counts consecutive cycles W is refused; any W grant or W withdrawal restarts it.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      starve_q <= '0;
    end else if (wbsr && !gnt_w) begin
      if (starve_q != SW'(STARVE_MAX)) starve_q <= starve_q + SW'(1);
    end else begin
      starve_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_qp_mem_arbiter.sv
// Scoreboard bench for qp_mem_arbiter: directed accesses push expected grants and read data,
// a negedge monitor pops and compares whenever a grant or rvalid appears.
module tb_qp_mem_arbiter;

  localparam int AW = 9;
  localparam int PW = 55;
  localparam logic [PW-1:0] D_BEEF = 55'h1010_DEAD_BEEF;
  localparam logic [PW-1:0] D_W5   = 55'hB_CDEF_0123_4567;
  localparam logic [PW-1:0] D_W7   = 55'h12345;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_ni;
  logic          wbs_mode;
  logic          eng_req, eng_we, eng_gnt, eng_rvalid;
  logic [AW-1:0] eng_addr;
  logic [PW-1:0] eng_wpatch, eng_rpatch;
  logic          wbs_req, wbs_we, wbs_gnt, wbs_rvalid;
  logic [AW-1:0] wbs_addr;
  logic [PW-1:0] wbs_wpatch, wbs_rpatch;
  logic          mem_csb0, mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [PW-1:0] mem_wpatch0;
  logic [PW-1:0] mem_rpatch0 = '0;
  logic [15:0]   conflict_cnt;

  typedef struct packed {
    logic          port;
    logic          csb;
    logic          web;
    logic [AW-1:0] addr;
    logic [PW-1:0] wpatch;
  } gnt_rec_t;

  typedef struct packed {
    logic          port;
    logic [PW-1:0] data;
  } rd_rec_t;

  gnt_rec_t gnt_q[$];
  rd_rec_t  rd_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  logic [PW-1:0] sram [0:511];

  always #5 wb_clk_i = ~wb_clk_i;

  qp_mem_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .wbs_mode(wbs_mode),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wpatch(eng_wpatch),
    .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rpatch(eng_rpatch),
    .wbs_req(wbs_req), .wbs_we(wbs_we), .wbs_addr(wbs_addr), .wbs_wpatch(wbs_wpatch),
    .wbs_gnt(wbs_gnt), .wbs_rvalid(wbs_rvalid), .wbs_rpatch(wbs_rpatch),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_wpatch0(mem_wpatch0), .mem_rpatch0(mem_rpatch0), .conflict_cnt(conflict_cnt)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge wb_clk_i) begin
    if (mem_csb0 === 1'b0) begin
      if (mem_web0 === 1'b0) sram[mem_addr0] <= mem_wpatch0;
      else                   mem_rpatch0 <= sram[mem_addr0];
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushGnt(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [PW-1:0] wpatch);
    gnt_rec_t r;
    r.port   = port;
    r.csb    = 1'b0;
    r.web    = ~we;
    r.addr   = addr;
    r.wpatch = wpatch;
    gnt_q.push_back(r);
  endtask

  task automatic pushRd(input logic port, input logic [PW-1:0] data);
    rd_rec_t r;
    r.port = port;
    r.data = data;
    rd_q.push_back(r);
  endtask

  task automatic pushE();
    pushGnt(1'b0, 1'b0, 9'd2, '0);
    pushRd(1'b0, D_BEEF);
  endtask

  task automatic pushW();
    pushGnt(1'b1, 1'b1, 9'd7, D_W7);
  endtask

  // Single access from one port; req held until granted, bounded wait.
  task automatic applyStimulus(input logic port, input logic we, input logic [AW-1:0] addr,
                               input logic [PW-1:0] wpatch, input logic [PW-1:0] exp_rdata);
    logic got;
    pushGnt(port, we, addr, wpatch);
    if (!we) pushRd(port, exp_rdata);
    if (port) begin
      wbs_we = we; wbs_addr = addr; wbs_wpatch = wpatch; wbs_req = 1'b1;
    end else begin
      eng_we = we; eng_addr = addr; eng_wpatch = wpatch; eng_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge wb_clk_i);
      got = port ? wbs_gnt : eng_gnt;
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL grant_timeout: port %0d got no grant, expected grant within 50 cycles", port);
    end
    @(posedge wb_clk_i);
    #1;
    if (port) wbs_req = 1'b0;
    else      eng_req = 1'b0;
  endtask

  task automatic runCycles(input int n, input logic e_on, input logic w_on, input logic mode);
    eng_req  = e_on;
    wbs_req  = w_on;
    wbs_mode = mode;
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge wb_clk_i) begin
    gnt_rec_t g_act;
    rd_rec_t  r_act;
    if (eng_gnt || wbs_gnt) begin
      checkOutput("gnt_onehot", 128'(eng_gnt & wbs_gnt), 128'(0));
      g_act.port   = wbs_gnt;
      g_act.csb    = mem_csb0;
      g_act.web    = mem_web0;
      g_act.addr   = mem_addr0;
      g_act.wpatch = mem_wpatch0;
      if (gnt_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_grant: got %h, expected no grant", g_act);
      end else begin
        checkOutput("grant", 128'(g_act), 128'(gnt_q.pop_front()));
      end
    end
    if (eng_rvalid || wbs_rvalid) begin
      checkOutput("rvalid_onehot", 128'(eng_rvalid & wbs_rvalid), 128'(0));
      r_act.port = wbs_rvalid;
      r_act.data = wbs_rvalid ? wbs_rpatch : eng_rpatch;
      if (rd_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_rvalid: got %h, expected no read data", r_act);
      end else begin
        checkOutput("read_data", 128'(r_act), 128'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic is_w;
    sram[2] = D_BEEF;
    wb_rst_ni = 1'b0; wbs_mode = 1'b1;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 9'd3; eng_wpatch = '0;
    wbs_req = 1'b1; wbs_we = 1'b1; wbs_addr = 9'd4; wbs_wpatch = 55'h77;

    // Reset held two cycles with both requesting.
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("rst_eng_gnt", 128'(eng_gnt), 128'(0));
    checkOutput("rst_wbs_gnt", 128'(wbs_gnt), 128'(0));
    checkOutput("rst_csb", 128'(mem_csb0), 128'(1));
    checkOutput("rst_web", 128'(mem_web0), 128'(1));
    checkOutput("rst_addr", 128'(mem_addr0), 128'(0));
    checkOutput("rst_wpatch", 128'(mem_wpatch0), 128'(0));
    checkOutput("rst_conflict", 128'(conflict_cnt), 128'(0));
    checkOutput("rst_rvalid", 128'({eng_rvalid, wbs_rvalid}), 128'(0));
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1; eng_req = 1'b0; wbs_req = 1'b0;

    // E read, then idle: SRAM address holds the last command.
    applyStimulus(1'b0, 1'b0, 9'd2, '0, D_BEEF);
    @(negedge wb_clk_i);
    checkOutput("idle_csb", 128'(mem_csb0), 128'(1));
    checkOutput("idle_web", 128'(mem_web0), 128'(1));
    checkOutput("idle_addr_hold", 128'(mem_addr0), 128'(2));
    @(posedge wb_clk_i);
    #1;

    // W write alone, then W read-back of the same word.
    applyStimulus(1'b1, 1'b1, 9'd5, D_W5, '0);
    applyStimulus(1'b1, 1'b0, 9'd5, '0, D_W5);
    checkOutput("conflict_none", 128'(conflict_cnt), 128'(0));

    // Continuous contention: E reads addr 2, W writes addr 7.
    eng_we = 1'b0; eng_addr = 9'd2; eng_wpatch = '0;
    wbs_we = 1'b1; wbs_addr = 9'd7; wbs_wpatch = D_W7;
    for (int k = 0; k < 10; k++) begin
`ifdef QP_ARB_RR_EN
      is_w = (k % 2 == 1);
`else
      is_w = (k == 4) || (k == 9);
`endif
      if (is_w) pushW();
      else      pushE();
    end
    runCycles(10, 1'b1, 1'b1, 1'b1);
    checkOutput("conflict_10", 128'(conflict_cnt), 128'(10));

    // Contention, then W masked by wbs_mode=0 for 20 cycles, then contention again.
    for (int i = 0; i < 27; i++) begin
`ifdef QP_ARB_RR_EN
      is_w = (i == 1) || (i == 22) || (i == 24) || (i == 26);
`else
      is_w = (i == 26);
`endif
      if (is_w) pushW();
      else      pushE();
    end
    runCycles(2, 1'b1, 1'b1, 1'b1);
    runCycles(20, 1'b1, 1'b1, 1'b0);
    checkOutput("conflict_masked", 128'(conflict_cnt), 128'(12));
    runCycles(5, 1'b1, 1'b1, 1'b1);
    eng_req = 1'b0; wbs_req = 1'b0; wbs_mode = 1'b1;
    checkOutput("conflict_17", 128'(conflict_cnt), 128'(17));
    repeat (2) @(posedge wb_clk_i);
    #1;

    // Reset in the cycle after an E read grant drops the read.
    eng_we = 1'b0; eng_addr = 9'd2; eng_wpatch = '0; eng_req = 1'b1;
    pushGnt(1'b0, 1'b0, 9'd2, '0);
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b0; eng_req = 1'b0;
    @(negedge wb_clk_i);
    checkOutput("rst_drop_rvalid", 128'(eng_rvalid), 128'(0));
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    checkOutput("rst2_rvalid", 128'(eng_rvalid), 128'(0));
    checkOutput("rst2_conflict", 128'(conflict_cnt), 128'(0));
    checkOutput("rst2_addr", 128'(mem_addr0), 128'(0));
    @(posedge wb_clk_i);
    #1;
    applyStimulus(1'b0, 1'b0, 9'd5, '0, D_W5);
    applyStimulus(1'b1, 1'b0, 9'd7, '0, D_W7);

    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("gnt_q_drained", 128'(gnt_q.size()), 128'(0));
    checkOutput("rd_q_drained", 128'(rd_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
